// File: rtl/nibble_serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl_if
// Description : Bundle of the upstream operand handshake, the downstream result
//               handshake and the connection to the external 4-bit adder.
//               slave  - the sequencer side
//               master - the environment side (producer, consumer, adder)
// Ports       : in_valid/in_ready/op_a/op_b/op_cin      upstream handshake
//               out_valid/out_ready/result/result_carry  downstream handshake
//               add_a/add_b/add_c -> adder, add_sum/add_carry <- adder
// Revision    : 1.0 - initial release
// ============================================================================
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_c;
  logic [3:0]       add_sum;
  logic             add_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             result_carry;

  modport slave (
    input  in_valid, op_a, op_b, op_cin, add_sum, add_carry, out_ready,
    output in_ready, add_a, add_b, add_c, out_valid, result, result_carry
  );

  modport master (
    output in_valid, op_a, op_b, op_cin, add_sum, add_carry, out_ready,
    input  in_ready, add_a, add_b, add_c, out_valid, result, result_carry
  );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl
// Description : Adds two WIDTH-bit operands through one external combinational
//               4-bit adder, one nibble per clock, LSB nibble first. The carry
//               between nibbles is chained through an internal register.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset
//               bus  - nibble_serial_adder_ctrl_if.slave (operand handshake,
//                      result handshake, external adder connection)
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  nibble_serial_adder_ctrl_if.slave   bus
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] result_reg;
  logic             result_carry_reg;

  // Handshake flags are pure state decodes, so reset alone yields in_ready=1,
  // out_valid=0 without any extra registers.
  always_comb begin
    bus.in_ready     = (state == S_IDLE);
    bus.out_valid    = (state == S_DONE);
    bus.result       = result_reg;
    bus.result_carry = result_carry_reg;
  end

  // Adder inputs are forced to zero outside RUN so the external adder sees a
  // quiet, known value whenever no nibble is in flight.
  always_comb begin
    bus.add_a = 4'd0;
    bus.add_b = 4'd0;
    bus.add_c = 1'b0;
    if (state == S_RUN) begin
      bus.add_a = a_reg[idx*4 +: 4];
      bus.add_b = b_reg[idx*4 +: 4];
      bus.add_c = carry_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      a_reg            <= '0;
      b_reg            <= '0;
      carry_reg        <= 1'b0;
      idx              <= '0;
      result_reg       <= '0;
      result_carry_reg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_reg      <= bus.op_a;
            b_reg      <= bus.op_b;
            carry_reg  <= bus.op_cin;
            idx        <= '0;
            result_reg <= '0;
            state      <= S_RUN;
          end
        end

        S_RUN: begin
          result_reg[idx*4 +: 4] <= bus.add_sum;
          carry_reg              <= bus.add_carry;
          if (idx == LAST_IDX) begin
            result_carry_reg <= bus.add_carry;
            idx              <= '0;
            state            <= S_DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        S_DONE: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_adder_ctrl
// Description : Directed self-checking bench for nibble_serial_adder_ctrl with a
//               real 4-bit adder model on the add_* connection. WIDTH=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 16;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External combinational 4-bit ripple-carry adder.
  assign {bus.add_carry, bus.add_sum} = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_c);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer operands from a negedge-aligned point; returns #1 after the accept edge.
  // The operand bus is scrambled afterwards to show late changes are ignored.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic cin);
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_cin   = cin;
    bus.in_valid = 1'b1;
    #1;
    check_value("accept_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op_a     = ~a;
    bus.op_b     = ~b;
    bus.op_cin   = ~cin;
  endtask

  // Counts edges after the accept edge until out_valid, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_op(input string tag, input logic [15:0] exp_res, input logic exp_c);
    check_value({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    check_value({tag, "_carry"}, 32'(bus.result_carry), 32'(exp_c));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_value({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check_value({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] exp_res, input logic exp_c);
    int lat;
    start_op(a, b, cin);
    wait_done(lat);
    check_value({tag, "_latency"}, 32'(lat), 32'd4);
    finish_op(tag, exp_res, exp_c);
  endtask

  initial begin
    int lat;
    logic [15:0] held;
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_a      = 16'h0;
    bus.op_b      = 16'h0;
    bus.op_cin    = 1'b0;
    bus.out_ready = 1'b0;

    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_value("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_value("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_value("rst_result", 32'(bus.result), 32'd0);
    check_value("rst_result_carry", 32'(bus.result_carry), 32'd0);
    check_value("rst_add", {23'd0, bus.add_a, bus.add_b, bus.add_c}, 32'd0);
    @(negedge clk);

    // 2: basic add, plus first-nibble adder drive and in_ready drop in RUN
    start_op(16'h1234, 16'h4321, 1'b0);
    check_value("run_in_ready", 32'(bus.in_ready), 32'd0);
    check_value("run_nib0_add", {23'd0, bus.add_a, bus.add_b, bus.add_c}, {23'd0, 4'h4, 4'h1, 1'b0});
    @(posedge clk);
    #1;
    check_value("run_nib1_add", {23'd0, bus.add_a, bus.add_b, bus.add_c}, {23'd0, 4'h3, 4'h2, 1'b0});
    wait_done(lat);
    check_value("add1_latency", 32'(lat), 32'd3);  // one edge already consumed above
    finish_op("add1", 16'h5555, 1'b0);
    @(negedge clk);

    // 3, 4: full carry ripple and carry-in cases
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    run_op("cin_wrap", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1);
    @(negedge clk);
    run_op("cin_mid", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0);
    @(negedge clk);
    run_op("mixed", 16'hA5C3, 16'h3C5A, 1'b1, 16'hE21E, 1'b0);
    @(negedge clk);

    // 5: backpressure; a new operand set is held valid throughout DONE
    start_op(16'h0102, 16'h0304, 1'b0);
    wait_done(lat);
    check_value("bp_latency", 32'(lat), 32'd4);
    bus.op_a     = 16'h1111;
    bus.op_b     = 16'h2222;
    bus.op_cin   = 1'b1;
    bus.in_valid = 1'b1;
    held = bus.result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_value("bp_valid_held", 32'(bus.out_valid), 32'd1);
      check_value("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check_value("bp_result_stable", 32'(bus.result), 32'(held));
    end
    check_value("bp_result", 32'(bus.result), 32'h0406);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_value("bp_back_idle", 32'(bus.in_ready), 32'd1);
    check_value("bp_valid_drop", 32'(bus.out_valid), 32'd0);
    @(posedge clk);  // second operand set accepted here
    #1;
    bus.in_valid = 1'b0;
    check_value("bp_next_accepted", 32'(bus.in_ready), 32'd0);
    wait_done(lat);
    check_value("bp2_latency", 32'(lat), 32'd4);
    finish_op("bp2", 16'h3334, 1'b0);
    @(negedge clk);

    // 6: reset mid-RUN at idx=2
    start_op(16'hFFFF, 16'hFFFF, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_value("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check_value("abort_result", 32'(bus.result), 32'd0);
    check_value("abort_add", {23'd0, bus.add_a, bus.add_b, bus.add_c}, 32'd0);
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) lat++;
    end
    check_value("abort_no_valid", 32'(lat), 32'd0);
    @(negedge clk);
    run_op("post_abort", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
